load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, maximum consecutive waitrequest-high cycles tolerated per transfer (range 1..65535).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  one-cycle request strobe, sampled in IDLE only.
REQ-005 op  input  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
REQ-006 addr  input  32  byte address.
REQ-007 store_data  input  32  CPU-order store operand; LSB-justified for SB/SH.
REQ-008 busy  output  1  high from accepted start until the cycle after done.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 load_data  output  32  extended load result, valid while done=1.
REQ-011 err  output  2  00 ok, 01 misaligned, 10 timeout; valid while done=1.
REQ-012 avm_address  output  32  {addr[31:2],2'b00}.
REQ-013 avm_read / avm_write  output  1 each  bus request strobes.
REQ-014 avm_byteenable  output  4  bit k = byte at address offset k.
REQ-015 avm_writedata  output  32  CPU-order data to the endian-swap stage.
REQ-016 avm_readdata  input  32  CPU-order data from the endian-swap stage.
REQ-017 avm_waitrequest  input  1  slave stall.

Function
REQ-018 Byte at offset k occupies bits [31-8k:24-8k] of avm_writedata/avm_readdata (big-endian CPU order).
REQ-019 FSM states IDLE, REQ, DONE; start ignored outside IDLE.
REQ-020 IDLE+start: latch op, addr, store_data; aligned -> REQ, misaligned -> DONE with err=01, no bus cycle.
REQ-021 Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00; byte ops never misaligned.
REQ-022 REQ: avm_read (loads) or avm_write (stores) high; address, byteenable and writedata held stable until waitrequest=0 is sampled.
REQ-023 REQ with waitrequest=0 at a clock edge: transfer completes, avm_readdata captured on that edge, next state DONE, err=00.
REQ-024 Wait counter clears on REQ entry and increments each edge with waitrequest=1; reaching TIMEOUT_CYCLES: drop strobe, go to DONE, err=10, load_data=0.
REQ-025 DONE lasts exactly one cycle with done=1, then IDLE; minimum start-to-done latency 2 clocks (start edge, completion edge).
REQ-026 Byteenable: byte ops 0001<<addr[1:0]; half ops 0011 (addr[1]=0) or 1100 (addr[1]=1); word ops 1111.
REQ-027 Writedata: SB {4{store_data[7:0]}}, SH {2{store_data[15:0]}}, SW store_data.
REQ-028 Loads: select byte/half per REQ-018; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-029 Stores complete with load_data=0; misaligned and timeout results also load_data=0.
REQ-030 avm_read and avm_write never high together; both low outside REQ.

Reset
REQ-031 rst_n low: immediately state IDLE, busy=0, done=0, err=00, load_data=0, avm_read=0, avm_write=0, avm_byteenable=0000, avm_address=0, avm_writedata=0, counter=0.
REQ-032 Reset during REQ aborts the transfer with no done pulse; first start after rst_n rises is accepted normally.

Verification
REQ-033 LB addr=0x103, readdata=0x112233F4, waitrequest=0 -> byteenable=1000, address=0x100, done next cycle, load_data=0xFFFFFFF4, err=00.
REQ-034 SH addr=0x202, store_data=0x0000BEEF -> avm_write=1, byteenable=1100, writedata=0xBEEFBEEF, done after completion edge.
REQ-035 LHU addr=0x10, readdata=0x8001ABCD, waitrequest high 3 cycles -> read/address stable 4 cycles, load_data=0x00008001.
REQ-036 LW addr=0x6 -> no avm_read, done on next cycle, err=01, load_data=0.
REQ-037 TIMEOUT_CYCLES=4, SW with waitrequest stuck high -> avm_write drops after 4 stalled edges, done, err=10.
REQ-038 rst_n pulsed low during REQ of LW -> avm_read falls asynchronously, no done; following LBU addr=0x1, readdata=0x00AA0000 -> load_data=0x000000AA.

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - word-wide memory bus between the load/store unit and the endian-swap stage
interface load_store_unit_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        output avm_write,
        output avm_byteenable,
        output avm_writedata,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_write,
        input  avm_byteenable,
        input  avm_writedata,
        output avm_readdata,
        output avm_waitrequest
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/half/word load-store sequencer with alignment check and stall timeout
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [2:0]                op,
    input  logic [31:0]               addr,
    input  logic [31:0]               store_data,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               load_data,
    output logic [1:0]                err,
    load_store_unit_if.master         avm
);

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [15:0] wait_cnt;
    logic [31:0] address_q;
    logic [3:0]  byteenable_q;
    logic [31:0] writedata_q;

    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic [3:0]  byteenable_in;
    logic [31:0] writedata_in;
    logic        is_store_q;
    logic        timeout_hit;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;

    // Request decode on the raw inputs; only meaningful in the IDLE+start cycle.
    always_comb begin
        is_byte    = (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
        is_half    = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        is_word    = !is_byte && !is_half;
        misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));

        if (is_byte) begin
            byteenable_in = 4'b0001 << addr[1:0];
            writedata_in  = {4{store_data[7:0]}};
        end else if (is_half) begin
            byteenable_in = addr[1] ? 4'b1100 : 4'b0011;
            writedata_in  = {2{store_data[15:0]}};
        end else begin
            byteenable_in = 4'b1111;
            writedata_in  = store_data;
        end
    end

    // Big-endian lanes: offset k lives at bits [31-8k -: 8], so the shift is 8*(3-k).
    always_comb begin
        is_store_q = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
        byte_sel   = avm.avm_readdata[{~off_q, 3'b000} +: 8];
        half_sel   = off_q[1] ? avm.avm_readdata[15:0] : avm.avm_readdata[31:16];
        case (op_q)
            OP_LB:   load_fmt = {{24{byte_sel[7]}}, byte_sel};
            OP_LH:   load_fmt = {{16{half_sel[15]}}, half_sel};
            OP_LW:   load_fmt = avm.avm_readdata;
            OP_LBU:  load_fmt = {24'd0, byte_sel};
            OP_LHU:  load_fmt = {16'd0, half_sel};
            default: load_fmt = 32'd0;
        endcase
    end

    assign timeout_hit = avm.avm_waitrequest && (wait_cnt == WAIT_LIMIT);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                if (!avm.avm_waitrequest || timeout_hit) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_q         <= OP_LB;
            off_q        <= 2'b00;
            wait_cnt     <= 16'd0;
            address_q    <= 32'd0;
            byteenable_q <= 4'b0000;
            writedata_q  <= 32'd0;
            load_data    <= 32'd0;
            err          <= ERR_OK;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q         <= op;
                        off_q        <= addr[1:0];
                        address_q    <= {addr[31:2], 2'b00};
                        byteenable_q <= byteenable_in;
                        writedata_q  <= writedata_in;
                        wait_cnt     <= 16'd0;
                        load_data    <= 32'd0;
                        err          <= misaligned ? ERR_MISALIGN : ERR_OK;
                    end
                end
                REQ: begin
                    if (!avm.avm_waitrequest) begin
                        err       <= ERR_OK;
                        load_data <= is_store_q ? 32'd0 : load_fmt;
                    end else if (timeout_hit) begin
                        err       <= ERR_TIMEOUT;
                        load_data <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy               = (state != IDLE);
    assign done               = (state == DONE);
    assign avm.avm_read       = (state == REQ) && !is_store_q;
    assign avm.avm_write      = (state == REQ) && is_store_q;
    assign avm.avm_address    = address_q;
    assign avm.avm_byteenable = byteenable_q;
    assign avm.avm_writedata  = writedata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a byte-level model
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic [1:0]  err;

    int vectors;
    int miscompares;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .err        (err),
        .avm        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int op_size(input logic [2:0] o);
        if (o == 3'd0 || o == 3'd3 || o == 3'd5) return 1;
        if (o == 3'd1 || o == 3'd4 || o == 3'd6) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] o, input logic [31:0] a, input logic [31:0] rd);
        logic [7:0] b [4];
        int off;
        for (int k = 0; k < 4; k++) b[k] = rd[31 - 8*k -: 8];
        off = int'(a[1:0]);
        case (o)
            3'd0: return 32'($signed(b[off]));
            3'd1: return 32'($signed({b[off], b[off+1]}));
            3'd2: return rd;
            3'd3: return {24'd0, b[off]};
            3'd4: return {16'd0, b[off], b[off+1]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] o, input logic [31:0] a);
        logic [3:0] be;
        int sz;
        sz = op_size(o);
        be = 4'b0000;
        for (int k = 0; k < sz; k++) be[int'(a[1:0]) + k] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] o, input logic [31:0] sd);
        case (op_size(o))
            1:       return {24'd0, sd[7:0]} * 32'h01010101;
            2:       return {16'd0, sd[15:0]} * 32'h00010001;
            default: return sd;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rd, input int stalls);
        int  sz;
        bit  mis;
        bit  st;
        bit  seen;
        int  n;
        int  exp_n;
        logic [1:0]  exp_err;
        logic [31:0] exp_ld;

        sz  = op_size(o);
        mis = (a % sz) != 0;
        st  = (o >= 3'd5);
        if (mis) begin
            exp_n = 0; exp_err = 2'b01; exp_ld = 32'd0;
        end else if (stalls >= TO) begin
            exp_n = TO; exp_err = 2'b10; exp_ld = 32'd0;
        end else begin
            exp_n = stalls + 1; exp_err = 2'b00; exp_ld = st ? 32'd0 : model_load(o, a, rd);
        end

        @(negedge clk);
        start = 1'b1; op = o; addr = a; store_data = sd;
        bus.avm_readdata = rd; bus.avm_waitrequest = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            n++;
            expect_eq("busy_req", 32'(busy), 32'(1));
            expect_eq("avm_read", 32'(bus.avm_read), 32'(!st));
            expect_eq("avm_write", 32'(bus.avm_write), 32'(st));
            expect_eq("avm_address", bus.avm_address, {a[31:2], 2'b00});
            expect_eq("avm_byteenable", 32'(bus.avm_byteenable), 32'(model_be(o, a)));
            if (st) expect_eq("avm_writedata", bus.avm_writedata, model_wd(o, sd));
            bus.avm_waitrequest = (n <= stalls);
            @(negedge clk);
        end
        expect_eq("done_seen", 32'(seen), 32'(1));
        expect_eq("strobe_cycles", 32'(n), 32'(exp_n));
        expect_eq("err", 32'(err), 32'(exp_err));
        expect_eq("load_data", load_data, exp_ld);
        expect_eq("busy_done", 32'(busy), 32'(1));
        expect_eq("strobes_low_done", 32'(bus.avm_read | bus.avm_write), 32'(0));
        bus.avm_waitrequest = 1'b0;
        @(negedge clk);
        expect_eq("done_one_cycle", 32'(done), 32'(0));
        expect_eq("busy_after", 32'(busy), 32'(0));
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op = 3'd0;
        addr = 32'd0;
        store_data = 32'd0;
        bus.avm_readdata = 32'd0;
        bus.avm_waitrequest = 1'b0;

        @(negedge clk);
        @(negedge clk);
        expect_eq("rst_busy", 32'(busy), 32'(0));
        expect_eq("rst_done", 32'(done), 32'(0));
        expect_eq("rst_err", 32'(err), 32'(0));
        expect_eq("rst_load_data", load_data, 32'd0);
        expect_eq("rst_strobes", 32'({bus.avm_read, bus.avm_write}), 32'(0));
        expect_eq("rst_be", 32'(bus.avm_byteenable), 32'(0));
        expect_eq("rst_address", bus.avm_address, 32'd0);
        expect_eq("rst_writedata", bus.avm_writedata, 32'd0);
        rst_n = 1'b1;

        run_op(3'd0, 32'h0000_0103, 32'd0, 32'h1122_33F4, 0);
        run_op(3'd6, 32'h0000_0202, 32'h0000_BEEF, 32'd0, 0);
        run_op(3'd4, 32'h0000_0010, 32'd0, 32'h8001_ABCD, 3);
        run_op(3'd2, 32'h0000_0006, 32'd0, 32'hDEAD_BEEF, 0);
        run_op(3'd7, 32'h0000_0300, 32'hCAFE_F00D, 32'd0, 100);
        run_op(3'd1, 32'h0000_0402, 32'd0, 32'h1234_F00F, TO - 1);

        // Abort an LW mid-request with an asynchronous reset.
        @(negedge clk);
        start = 1'b1; op = 3'd2; addr = 32'h0000_0040; bus.avm_waitrequest = 1'b0;
        @(negedge clk);
        start = 1'b0;
        bus.avm_waitrequest = 1'b1;
        expect_eq("abort_read_before", 32'(bus.avm_read), 32'(1));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        expect_eq("abort_read_falls", 32'(bus.avm_read), 32'(0));
        expect_eq("abort_busy", 32'(busy), 32'(0));
        expect_eq("abort_done", 32'(done), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        bus.avm_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            expect_eq("abort_no_done", 32'(done), 32'(0));
        end
        run_op(3'd3, 32'h0000_0001, 32'd0, 32'h00AA_0000, 0);

        for (int i = 0; i < 200; i++) begin
            logic [2:0]  r_op;
            logic [31:0] r_addr;
            r_op = 3'($urandom_range(0, 7));
            r_addr = $urandom;
            if ($urandom_range(0, 3) != 0) r_addr[1:0] = 2'(op_size(r_op) == 1 ? r_addr[1:0] :
                                                            op_size(r_op) == 2 ? {r_addr[1], 1'b0} : 2'b00);
            run_op(r_op, r_addr, $urandom, $urandom, int'($urandom_range(0, TO + 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
